// File: rtl/cim_serial_add_sequencer.sv
// Bit-serial, bit-sliced add sequencer for the CIM datapath: walks operand
// rows, drives dual-port SRAM reads, steps the lane carry and writes sums back.
// Ports: sys_clk_in/sys_reset_in; start_in/abort_in command; a/b/dst_base_in,
// width_m1_in, carry_init_in command fields; result_in adder sum slice;
// sram_* port controls; read_sel_out; load/update_carry_out, carry_out;
// busy_out, done_out status.
module cim_serial_add_sequencer #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  sys_clk_in,
  input  logic                  sys_reset_in,
  input  logic                  start_in,
  input  logic                  abort_in,
  input  logic [ADDR_WIDTH-1:0] a_base_in,
  input  logic [ADDR_WIDTH-1:0] b_base_in,
  input  logic [ADDR_WIDTH-1:0] dst_base_in,
  input  logic [4:0]            width_m1_in,
  input  logic                  carry_init_in,
  input  logic [31:0]           result_in,
  output logic [ADDR_WIDTH-1:0] sram_addr_a_out,
  output logic [ADDR_WIDTH-1:0] sram_addr_b_out,
  output logic [31:0]           sram_data_a_out,
  output logic                  sram_wren_a_out,
  output logic [3:0]            read_sel_out,
  output logic                  load_carry_out,
  output logic [31:0]           carry_out,
  output logic                  update_carry_out,
  output logic                  busy_out,
  output logic                  done_out
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    READ,
    WRITE,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [4:0]            k, k_nx;
  logic [ADDR_WIDTH-1:0] a_base, b_base, dst_base;
  logic [4:0]            width_m1;
  logic                  carry_init;
  logic [ADDR_WIDTH-1:0] k_ext;

  assign k_ext = ADDR_WIDTH'(k);

  always_ff @(posedge sys_clk_in or negedge sys_reset_in) begin
    if (!sys_reset_in) begin
      state      <= IDLE;
      k          <= '0;
      a_base     <= '0;
      b_base     <= '0;
      dst_base   <= '0;
      width_m1   <= '0;
      carry_init <= 1'b0;
    end else begin
      state <= state_nx;
      k     <= k_nx;
      if (state == IDLE && start_in) begin
        a_base     <= a_base_in;
        b_base     <= b_base_in;
        dst_base   <= dst_base_in;
        width_m1   <= width_m1_in;
        carry_init <= carry_init_in;
      end
    end
  end

  always_comb begin
    state_nx         = state;
    k_nx             = k;
    sram_addr_a_out  = '0;
    sram_addr_b_out  = '0;
    sram_data_a_out  = '0;
    sram_wren_a_out  = 1'b0;
    read_sel_out     = 4'h0;
    load_carry_out   = 1'b0;
    carry_out        = '0;
    update_carry_out = 1'b0;
    busy_out         = 1'b0;
    done_out         = 1'b0;

    unique case (state)
      IDLE: begin
        if (start_in) begin
          state_nx = LOAD;
          k_nx     = '0;
        end
      end
      LOAD: begin
        busy_out       = 1'b1;
        read_sel_out   = 4'h8;
        load_carry_out = 1'b1;
        carry_out      = {32{carry_init}};
        state_nx       = READ;
      end
      READ: begin
        busy_out        = 1'b1;
        read_sel_out    = 4'h8;
        sram_addr_a_out = a_base + k_ext;
        sram_addr_b_out = b_base + k_ext;
        state_nx        = WRITE;
      end
      WRITE: begin
        busy_out         = 1'b1;
        read_sel_out     = 4'h8;
        sram_addr_a_out  = dst_base + k_ext;
        sram_data_a_out  = result_in;
        // abort gates the write in the same cycle
        sram_wren_a_out  = !abort_in;
        update_carry_out = 1'b1;
        if (k == width_m1) begin
          state_nx = DONE;
        end else begin
          k_nx     = k + 5'd1;
          state_nx = READ;
        end
      end
      DONE: begin
        busy_out     = 1'b1;
        read_sel_out = 4'h8;
        done_out     = 1'b1;
        state_nx     = IDLE;
      end
      default: state_nx = IDLE;
    endcase

    if (state != IDLE && abort_in) begin
      state_nx = IDLE;
    end
  end

endmodule
